// File: rtl/fir_param_stream.sv
// Pipelined signed direct-form FIR with run-time programmable coefficients,
// valid handshaking, round-half-up scaling, output saturation and a synchronous flush.
module fir_param_stream #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      flush,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      out_valid,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      sat_flag
);

  localparam int ADDR_W = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  // One guard bit above the nominal sum width keeps the rounding add from overflowing.
  localparam int ACC_W  = PROD_W + $clog2(TAPS) + 1;
  localparam int R_W    = ACC_W - SHIFT;

  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [R_W-1:0]   MAX_R = R_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [R_W-1:0]   MIN_R = ~MAX_R;

  logic signed [DATA_W-1:0] d_q    [TAPS];
  logic signed [DATA_W-1:0] d_d    [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];
  logic signed [PROD_W-1:0] p_q    [TAPS];
  logic signed [PROD_W-1:0] p_d    [TAPS];

  logic                     v1_q, v1_d;
  logic                     v2_q, v2_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     sat_q, sat_d;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [R_W-1:0]    r;
  logic signed [OUT_W-1:0]  r_sat;
  logic                     r_clip;

  always_comb begin
    d_d = d_q;
    if (flush) begin
      for (int i = 0; i < TAPS; i++) d_d[i] = '0;
    end else if (in_valid) begin
      d_d[0] = in_data;
      for (int i = 1; i < TAPS; i++) d_d[i] = d_q[i-1];
    end
  end

  // Out-of-range addresses match no tap, so such writes are silently dropped.
  always_comb begin
    coef_d = coef_q;
    if (coef_we) begin
      for (int i = 0; i < TAPS; i++) begin
        if (coef_addr == ADDR_W'(i)) coef_d[i] = coef_data;
      end
    end
  end

  always_comb begin
    p_d = p_q;
    if (flush) begin
      for (int i = 0; i < TAPS; i++) p_d[i] = '0;
    end else if (v1_q) begin
      for (int i = 0; i < TAPS; i++) p_d[i] = PROD_W'(d_q[i]) * PROD_W'(coef_q[i]);
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < TAPS; i++) acc = acc + ACC_W'(p_q[i]);
    acc_rnd = acc + HALF;
    r       = R_W'(acc_rnd >>> SHIFT);
    if (r > MAX_R) begin
      r_sat  = MAX_R[OUT_W-1:0];
      r_clip = 1'b1;
    end else if (r < MIN_R) begin
      r_sat  = MIN_R[OUT_W-1:0];
      r_clip = 1'b1;
    end else begin
      r_sat  = r[OUT_W-1:0];
      r_clip = 1'b0;
    end
  end

  // Flush kills in-flight valids but leaves the last published result in place.
  always_comb begin
    v1_d        = in_valid & ~flush;
    v2_d        = v1_q & ~flush;
    out_valid_d = v2_q & ~flush;
    out_data_d  = out_data_q;
    sat_d       = sat_q;
    if (v2_q && !flush) begin
      out_data_d = r_sat;
      sat_d      = r_clip;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        d_q[i]    <= '0;
        p_q[i]    <= '0;
        coef_q[i] <= (i == 0) ? COEF_W'(1 << SHIFT) : '0;
      end
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      d_q         <= d_d;
      p_q         <= p_d;
      coef_q      <= coef_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fir_param_stream.sv
// Randomised and directed bench for fir_param_stream, checked against a
// behavioural model that keeps sample history, coefficients and due-cycle queue.
module tb_fir_param_stream;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 8;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 6;
  localparam int ADDR_W = $clog2(TAPS);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     flush;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     sat_flag;

  fir_param_stream #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_data(out_data), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int data;
    int sat;
  } exp_t;

  int   assertCount = 0;
  int   failCount   = 0;
  int   cyc         = 0;
  int   histM [TAPS];
  int   coefM [TAPS];
  int   lastData;
  int   lastSat;
  exp_t expQ [$];

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < TAPS; i++) begin
      histM[i] = 0;
      coefM[i] = 0;
    end
    coefM[0] = 1 << SHIFT;
    expQ.delete();
    lastData = 0;
    lastSat  = 0;
  endfunction

  // Filter output as plain integer arithmetic: dot product, round half up, clamp.
  function automatic void modelEdge(input bit v, input int data, input bit fl,
                                    input bit we, input int addr, input int cdata);
    int   acc;
    int   r;
    exp_t e;
    if (we && addr < TAPS) coefM[addr] = cdata;
    if (fl) begin
      for (int i = 0; i < TAPS; i++) histM[i] = 0;
      expQ.delete();
    end else if (v) begin
      for (int i = TAPS - 1; i > 0; i--) histM[i] = histM[i-1];
      histM[0] = data;
      acc = 0;
      for (int i = 0; i < TAPS; i++) acc += histM[i] * coefM[i];
      r = (acc + (1 << (SHIFT - 1))) >>> SHIFT;
      e.due = cyc + 2;
      e.sat = 0;
      if (r > (1 << (OUT_W - 1)) - 1) begin
        e.data = (1 << (OUT_W - 1)) - 1;
        e.sat  = 1;
      end else if (r < -(1 << (OUT_W - 1))) begin
        e.data = -(1 << (OUT_W - 1));
        e.sat  = 1;
      end else begin
        e.data = r;
      end
      expQ.push_back(e);
    end
  endfunction

  task automatic applyStimulus(input bit v, input int data, input bit fl,
                               input bit we, input int addr, input int cdata);
    exp_t e;
    in_valid  = v;
    in_data   = DATA_W'(data);
    flush     = fl;
    coef_we   = we;
    coef_addr = ADDR_W'(addr);
    coef_data = COEF_W'(cdata);
    @(posedge clk);
    cyc++;
    modelEdge(v, data, fl, we, addr, cdata);
    #1;
    if (expQ.size() > 0 && expQ[0].due == cyc) begin
      e = expQ.pop_front();
      checkOutput("out_valid pulse", out_valid, 1);
      checkOutput("out_data", out_data, e.data);
      checkOutput("sat_flag", sat_flag, e.sat);
      lastData = e.data;
      lastSat  = e.sat;
    end else begin
      checkOutput("out_valid idle", out_valid, 0);
      checkOutput("out_data hold", out_data, lastData);
      checkOutput("sat_flag hold", sat_flag, lastSat);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic sample(input int data);
    applyStimulus(1, data, 0, 0, 0, 0);
  endtask

  task automatic setRampCoefs();
    for (int i = 0; i < TAPS; i++) applyStimulus(0, 0, 0, 1, i, i + 1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #2;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset sat_flag", sat_flag, 0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    rst_n     = 1'b1;
    #3;
    doReset();

    $display("[TB] identity impulse after reset");
    sample(37);
    idle(3);

    $display("[TB] programmed taps 1..N with impulse 64");
    setRampCoefs();
    sample(64);
    for (int i = 1; i < TAPS; i++) sample(0);
    sample(0);
    idle(3);

    $display("[TB] saturation both rails");
    for (int i = 0; i < TAPS; i++) applyStimulus(0, 0, 0, 1, i, 127);
    for (int i = 0; i < TAPS; i++) sample(127);
    for (int i = 0; i < TAPS; i++) sample(-128);
    idle(3);

    $display("[TB] coefficient rewrite during a ramp");
    setRampCoefs();
    for (int i = 0; i < 12; i++) begin
      if (i == 6) applyStimulus(1, i * 3 - 10, 0, 1, 0, -40);
      else        sample(i * 3 - 10);
    end
    idle(3);

    $display("[TB] flush mid-stream then clean impulse");
    setRampCoefs();
    for (int i = 0; i < 5; i++) sample(20 + i);
    applyStimulus(1, 99, 1, 0, 0, 0);
    idle(4);
    sample(64);
    for (int i = 1; i < TAPS; i++) sample(0);
    idle(3);

    $display("[TB] flush with simultaneous coefficient write");
    sample(10);
    applyStimulus(1, 50, 1, 1, 3, -7);
    idle(3);

    $display("[TB] randomised traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, int'($urandom_range(0, 255)) - 128,
                    ($urandom % 40) == 0, ($urandom % 8) == 0,
                    int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)) - 128);
    end
    idle(3);

    $display("[TB] reset asserted mid-stream");
    for (int i = 0; i < 4; i++) sample(int'($urandom_range(0, 255)) - 128);
    doReset();
    idle(4);
    sample(37);
    idle(3);

    checkOutput("model queue drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
